// File: rtl/gate_test_sequencer.sv
// Self-test sequencer for the NOT/AND/OR gate block: sweeps {A,B}, checks outputs.
// Optional first-failure capture when GATE_SEQ_FAIL_CAPTURE_EN is defined.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SWEEPS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       out_not,
  input  logic       out_and,
  input  logic       out_or,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] vec_idx
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  ,
  output logic [1:0] fail_vec,
  output logic [2:0] fail_obs
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] APPLY  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_SWEEP  = 8'(SWEEPS - 1);

  logic [2:0] state;
  logic [7:0] settle_cnt;
  logic [7:0] sweep_cnt;
  logic [2:0] obs;
  logic [2:0] exp_out;
  logic       mismatch;
  logic       last_vec;
  logic [7:0] err_next;

  assign obs      = {out_not, out_and, out_or};
  assign exp_out  = {~vec_idx[1],
                     vec_idx[1] & vec_idx[0],
                     vec_idx[1] | vec_idx[0]};
  assign mismatch = (obs != exp_out);
  assign last_vec = (vec_idx == 2'd3) &&
                    (sweep_cnt == LAST_SWEEP);

  always_comb begin
    err_next = err_count;
    if (mismatch && err_count != 8'hff)
      err_next = err_count + 8'd1;
  end

  assign busy = (state == APPLY) ||
                (state == SETTLE) ||
                (state == CHECK);
  assign done = (state == FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      sweep_cnt  <= '0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      vec_idx    <= '0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
      fail_vec   <= '0;
      fail_obs   <= '0;
`endif
    end else if (state != IDLE && abort) begin
      state  <= IDLE;
      gate_a <= 1'b0;
      gate_b <= 1'b0;
      pass   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= APPLY;
            err_count <= '0;
            pass      <= 1'b0;
            vec_idx   <= '0;
            sweep_cnt <= '0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
            fail_vec  <= '0;
            fail_obs  <= '0;
`endif
          end
        end
        APPLY: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 8'd1;
          if (settle_cnt == 8'd1)
            state <= CHECK;
        end
        CHECK: begin
          err_count <= err_next;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
          // err_count is zero until the first failure of the run
          if (mismatch && err_count == 8'd0) begin
            fail_vec <= vec_idx;
            fail_obs <= obs;
          end
`endif
          if (last_vec) begin
            state  <= FINISH;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
            pass   <= (err_next == 8'd0);
          end else begin
            state            <= APPLY;
            vec_idx          <= vec_idx + 2'd1;
            {gate_a, gate_b} <= vec_idx + 2'd1;
            if (vec_idx == 2'd3)
              sweep_cnt <= sweep_cnt + 8'd1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Sequential self-test controller for the three-output logic-gate block (NOT of A, AND of A/B, OR of A/B). It drives the gate block's A/B inputs through all four input combinations, waits a programmable settle time per vector, and compares the three gate outputs against the truth table. It counts mismatches and reports pass/fail with a start/done handshake. It sits between a test host (or a top-level BIST FSM) and the gate block.

## Interface
Parameters:
- SETTLE_CYCLES, 4, number of cycles between driving a vector and sampling the outputs; legal range 1..255.
- SWEEPS, 1, number of full 4-vector sweeps per run; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  cancels a run in progress.
- gate_a  out  1  drives gate block input A.
- gate_b  out  1  drives gate block input B.
- out_not  in  1  gate block NOT output.
- out_and  in  1  gate block AND output.
- out_or  in  1  gate block OR output.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a completed run.
- pass  out  1  high when the last completed run had zero mismatches.
- err_count  out  8  number of mismatching vector checks; saturates at 255.
- vec_idx  out  2  current vector, encoded as {A,B}.
- fail_vec  out  2  first failing vector; present only with GATE_SEQ_FAIL_CAPTURE_EN.
- fail_obs  out  3  observed {not,and,or} at the first failure; present only with GATE_SEQ_FAIL_CAPTURE_EN.

## Operation
- States:
  - IDLE: busy=0. start=1 and abort=0 → APPLY; err_count, pass and the capture registers clear; vec_idx=0; sweep counter=0.
  - APPLY: 1 cycle; registered gate_a/gate_b={A,B}=vec_idx → SETTLE. Settle counter loads SETTLE_CYCLES.
  - SETTLE: decrements the settle counter each cycle; after SETTLE_CYCLES cycles → CHECK.
  - CHECK: 1 cycle; compares {out_not,out_and,out_or} with expected {~A, A&B, A|B}.
    - Any bit differs → err_count+1, saturating. At most one count per vector check.
    - If vec_idx=3 and sweep=SWEEPS-1 → FINISH.
    - Else vec_idx+1, wrapping 3→0 and incrementing sweep → APPLY.
  - FINISH: 1 cycle; done=1; pass=(err_count==0); gate_a/gate_b=0 → IDLE.
- Vector order: 00, 01, 10, 11, repeated SWEEPS times.
- busy=1 in APPLY, SETTLE and CHECK; busy=0 in FINISH and IDLE.
- abort=1 in any non-IDLE state → IDLE on the next edge:
  - no done pulse; pass=0; gate_a/gate_b=0;
  - err_count keeps its value.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, the block stays IDLE.
- pass holds its value until the next accepted start or reset.

## Timing
- Reset values: state IDLE; gate_a=0, gate_b=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, fail_vec=0, fail_obs=0.
- Reset asserted mid-run forces these values immediately, without waiting for a clock edge.
- Start accepted at edge E0 → APPLY for cycle 1.
- Each vector occupies SETTLE_CYCLES+2 cycles.
- done is high in cycle 4·SWEEPS·(SETTLE_CYCLES+2)+1 after E0; with the defaults this is cycle 25.
- Gate outputs are sampled at the edge that ends the CHECK cycle. The gate block must settle within SETTLE_CYCLES cycles.
- A new start is accepted no earlier than the edge that ends the FINISH cycle, i.e. in the cycle after done.

## Configuration
- GATE_SEQ_FAIL_CAPTURE_EN defined:
  - fail_vec and fail_obs exist.
  - On the first mismatching CHECK of a run, they latch vec_idx and the observed {out_not,out_and,out_or}.
  - Later failures do not overwrite them; they clear on an accepted start.
- GATE_SEQ_FAIL_CAPTURE_EN undefined: fail_vec and fail_obs and their registers are omitted. All other behaviour is identical.

## Test plan
- Good gate model, defaults, start pulse → gate_{a,b} steps 00,01,10,11, each held 6 cycles; done in cycle 25 after the start edge; pass=1, err_count=0.
- out_and stuck-at-1 → err_count=3 (vectors 00,01,10), pass=0; with the macro: fail_vec=2'b00, fail_obs=3'b110.
- SWEEPS=3, out_or stuck-at-0 → err_count=9, pass=0; done in cycle 73.
- abort during SETTLE of vec_idx=2 → next cycle busy=0, gate_a/b=0, no done, pass=0, err_count retains 0; a second start pulse while busy is ignored.
- SWEEPS=100, out_not inverted → 400 mismatches; err_count saturates at 255; pass=0.
- reset asserted during CHECK → all outputs go to reset values without waiting for a clock edge; after release, a start runs a full clean pass (pass=1).
